// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Typed view of the same encodings, used on the debug state output
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  // Bit positions inside the sticky error vector
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_LD_BUSY = 1;

  // Width of a counter that must hold values 0..timeout
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with load and increment enables; load has priority.
module pc_register
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_inc
);

  logic [ADDR_W-1:0] r_pc;

  // PC register: async reset, then load from the mux or step by one
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= o_pc_inc;
    end
  end

  // Wraps naturally at 2^ADDR_W
  assign o_pc     = r_pc;
  assign o_pc_inc = r_pc + ADDR_W'(1);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PC, MAR and IR and runs the memory read.
//
// Memory handshake: MEM_REQ is a level held from the REQ state through WAIT,
// with MEM_ADDR frozen for that whole window. A transfer completes on the
// first WAIT cycle where MEM_REQ and MEM_READY are both high; MEM_READY in
// REQ is ignored because memory is still sampling the address. If no
// transfer occurs within TIMEOUT WAIT cycles the request is withdrawn.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] PCMUX_OUT,
  input  logic              LD_PC,
  input  logic              FETCH_START,
  input  logic              MEM_READY,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_INCREMENT,
  output logic [DATA_W-1:0] IR,
  output logic              IR_VALID,
  output logic              FETCH_BUSY,
  output logic [1:0]        ERR,
  output fetch_state_t      o_dbg_state
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);

  logic [1:0]        r_state;
  logic              r_pending;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_ir;
  logic [1:0]        r_err;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic              w_in_idle;
  logic              w_start;
  logic              w_ld_pc;
  logic              w_pc_inc_en;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_start     = FETCH_START | r_pending;
  assign w_ld_pc     = LD_PC & w_in_idle;
  assign w_pc_inc_en = (r_state == ST_WAIT) & MEM_READY;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .i_load     (w_ld_pc),
    .i_load_val (PCMUX_OUT),
    .i_inc      (w_pc_inc_en),
    .o_pc       (w_pc),
    .o_pc_inc   (w_pc_inc)
  );

  // Fetch sequencer with MAR, IR, wait counter and sticky error capture
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_mem_addr <= '0;
      r_ir       <= '0;
      r_err      <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (LD_PC && !w_in_idle) begin
        r_err[ERR_LD_BUSY] <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            if (LD_PC) begin
              // PC is being replaced this cycle; start once the new value lands
              r_pending <= 1'b1;
            end else begin
              r_mem_addr <= w_pc;
              r_pending  <= 1'b0;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (MEM_READY) begin
            r_ir    <= MEM_RDATA;
            r_state <= ST_DONE;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_err[ERR_TIMEOUT] <= 1'b1;
            r_state            <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MEM_REQ      = (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign MEM_ADDR     = r_mem_addr;
  assign PC           = w_pc;
  assign PC_INCREMENT = w_pc_inc;
  assign IR           = r_ir;
  assign IR_VALID     = (r_state == ST_DONE);
  assign FETCH_BUSY   = !w_in_idle;
  assign ERR          = r_err;
  assign o_dbg_state  = fetch_state_t'(r_state);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: PC load, fetch latency, wrap, timeout, reset.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic         Clk;
  logic         Reset_n;
  logic [15:0]  PCMUX_OUT;
  logic         LD_PC;
  logic         FETCH_START;
  logic         MEM_READY;
  logic [15:0]  MEM_RDATA;
  logic         MEM_REQ;
  logic [15:0]  MEM_ADDR;
  logic [15:0]  PC;
  logic [15:0]  PC_INCREMENT;
  logic [15:0]  IR;
  logic         IR_VALID;
  logic         FETCH_BUSY;
  logic [1:0]   ERR;
  fetch_state_t dbg_state;

  int n_cmp;
  int n_fail;

  fetch_stage #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .TIMEOUT  (4)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .PCMUX_OUT    (PCMUX_OUT),
    .LD_PC        (LD_PC),
    .FETCH_START  (FETCH_START),
    .MEM_READY    (MEM_READY),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_REQ      (MEM_REQ),
    .MEM_ADDR     (MEM_ADDR),
    .PC           (PC),
    .PC_INCREMENT (PC_INCREMENT),
    .IR           (IR),
    .IR_VALID     (IR_VALID),
    .FETCH_BUSY   (FETCH_BUSY),
    .ERR          (ERR),
    .o_dbg_state  (dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n     = 1'b0;
    PCMUX_OUT   = '0;
    LD_PC       = 1'b0;
    FETCH_START = 1'b0;
    MEM_READY   = 1'b0;
    MEM_RDATA   = '0;
    #22;
    Reset_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PC, 16'h0000); end
    n_cmp++; if (PC_INCREMENT !== 16'h0001) begin n_fail++; $display("FAIL reset_pc_inc: got %h expected %h", PC_INCREMENT, 16'h0001); end
    n_cmp++; if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", MEM_REQ); end
    n_cmp++; if (ERR !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", ERR); end
    n_cmp++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h expected 0000", IR); end
    n_cmp++; if (IR_VALID !== 1'b0 || FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got valid=%b busy=%b expected 0/0", IR_VALID, FETCH_BUSY); end
    n_cmp++; if (MEM_ADDR !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", MEM_ADDR); end
  endtask

  task automatic test_basic_fetch();
    int pulses;
    PCMUX_OUT = 16'h3000;
    LD_PC     = 1'b1;
    tick();
    LD_PC = 1'b0;
    n_cmp++; if (PC !== 16'h3000) begin n_fail++; $display("FAIL basic_ld_pc: got %h expected 3000", PC); end
    FETCH_START = 1'b1;
    tick();
    FETCH_START = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 3) begin
        n_cmp++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h3000) begin n_fail++; $display("FAIL basic_req_c%0d: got req=%b addr=%h expected 1/3000", c, MEM_REQ, MEM_ADDR); end
      end
      if (c == 4) begin
        n_cmp++; if (IR !== 16'h1234) begin n_fail++; $display("FAIL basic_ir: got %h expected 1234", IR); end
        n_cmp++; if (PC !== 16'h3001) begin n_fail++; $display("FAIL basic_pc: got %h expected 3001", PC); end
        n_cmp++; if (IR_VALID !== 1'b1 || MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL basic_done: got valid=%b req=%b expected 1/0", IR_VALID, MEM_REQ); end
        n_cmp++; if (MEM_ADDR !== 16'h3000) begin n_fail++; $display("FAIL basic_addr_hold: got %h expected 3000", MEM_ADDR); end
      end
      if (IR_VALID === 1'b1) pulses++;
      MEM_READY = (c == 3);
      MEM_RDATA = (c == 3) ? 16'h1234 : 16'hDEAD;
      tick();
    end
    MEM_READY = 1'b0;
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    n_cmp++; if (FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b expected 0", FETCH_BUSY); end
  endtask

  task automatic test_ld_and_start();
    PCMUX_OUT   = 16'h00FF;
    LD_PC       = 1'b1;
    FETCH_START = 1'b1;
    tick();
    LD_PC       = 1'b0;
    FETCH_START = 1'b0;
    n_cmp++; if (PC !== 16'h00FF) begin n_fail++; $display("FAIL ldst_pc: got %h expected 00FF", PC); end
    n_cmp++; if (MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL ldst_req_delay: got %b expected 0", MEM_REQ); end
    tick();
    n_cmp++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h00FF) begin n_fail++; $display("FAIL ldst_req: got req=%b addr=%h expected 1/00FF", MEM_REQ, MEM_ADDR); end
    tick();
    MEM_READY = 1'b1;
    MEM_RDATA = 16'hABCD;
    tick();
    MEM_READY = 1'b0;
    n_cmp++; if (IR !== 16'hABCD || PC !== 16'h0100) begin n_fail++; $display("FAIL ldst_result: got ir=%h pc=%h expected ABCD/0100", IR, PC); end
    n_cmp++; if (IR_VALID !== 1'b1) begin n_fail++; $display("FAIL ldst_valid: got %b expected 1", IR_VALID); end
    tick();
  endtask

  task automatic test_pc_wrap();
    PCMUX_OUT = 16'hFFFF;
    LD_PC     = 1'b1;
    tick();
    LD_PC = 1'b0;
    n_cmp++; if (PC_INCREMENT !== 16'h0000) begin n_fail++; $display("FAIL wrap_inc_ffff: got %h expected 0000", PC_INCREMENT); end
    FETCH_START = 1'b1;
    tick();
    FETCH_START = 1'b0;
    // Ready asserted already in REQ: must be ignored there
    MEM_READY = 1'b1;
    MEM_RDATA = 16'h5A5A;
    tick();
    n_cmp++; if (MEM_REQ !== 1'b1 || IR !== 16'hABCD || dbg_state !== WAIT) begin n_fail++; $display("FAIL wrap_req_ignore: got req=%b ir=%h st=%0d expected 1/ABCD/2", MEM_REQ, IR, dbg_state); end
    tick();
    MEM_READY = 1'b0;
    n_cmp++; if (PC !== 16'h0000 || PC_INCREMENT !== 16'h0001) begin n_fail++; $display("FAIL wrap_pc: got pc=%h inc=%h expected 0000/0001", PC, PC_INCREMENT); end
    n_cmp++; if (IR !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_ir: got %h expected 5A5A", IR); end
    tick();
  endtask

  task automatic test_timeout();
    int reqs;
    int pulses;
    PCMUX_OUT = 16'h2222;
    LD_PC     = 1'b1;
    tick();
    LD_PC       = 1'b0;
    FETCH_START = 1'b1;
    tick();
    FETCH_START = 1'b0;
    reqs   = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (MEM_REQ === 1'b1) reqs++;
      if (IR_VALID === 1'b1) pulses++;
      tick();
    end
    n_cmp++; if (reqs != 5) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected 5", reqs); end
    n_cmp++; if (ERR !== 2'b01) begin n_fail++; $display("FAIL to_err: got %b expected 01", ERR); end
    n_cmp++; if (IR !== 16'h5A5A || PC !== 16'h2222) begin n_fail++; $display("FAIL to_unchanged: got ir=%h pc=%h expected 5A5A/2222", IR, PC); end
    n_cmp++; if (pulses != 0 || FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL to_no_valid: got pulses=%0d busy=%b expected 0/0", pulses, FETCH_BUSY); end
    n_cmp++; if (MEM_ADDR !== 16'h2222) begin n_fail++; $display("FAIL to_addr: got %h expected 2222", MEM_ADDR); end
  endtask

  task automatic test_ld_busy_and_async_reset();
    FETCH_START = 1'b1;
    tick();
    FETCH_START = 1'b0;
    PCMUX_OUT   = 16'h1111;
    LD_PC       = 1'b1;
    tick();
    LD_PC = 1'b0;
    n_cmp++; if (ERR !== 2'b11) begin n_fail++; $display("FAIL ldbusy_err: got %b expected 11", ERR); end
    n_cmp++; if (PC !== 16'h2222 || dbg_state !== WAIT) begin n_fail++; $display("FAIL ldbusy_pc: got pc=%h st=%0d expected 2222/2", PC, dbg_state); end
    #2;
    Reset_n = 1'b0;
    #1;
    n_cmp++; if (MEM_REQ !== 1'b0 || FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL areset_req: got req=%b busy=%b expected 0/0", MEM_REQ, FETCH_BUSY); end
    n_cmp++; if (PC !== 16'h0000 || ERR !== 2'b00) begin n_fail++; $display("FAIL areset_state: got pc=%h err=%b expected 0000/00", PC, ERR); end
    n_cmp++; if (IR !== 16'h0000 || MEM_ADDR !== 16'h0000) begin n_fail++; $display("FAIL areset_regs: got ir=%h addr=%h expected 0000/0000", IR, MEM_ADDR); end
    #3;
    Reset_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (MEM_REQ !== 1'b0 || PC !== 16'h0000) begin n_fail++; $display("FAIL areset_after: got req=%b pc=%h expected 0/0000", MEM_REQ, PC); end
  endtask

  // Test sequence and final report
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic_fetch();
    test_ld_and_start();
    test_pc_wrap();
    test_timeout();
    test_ld_busy_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
